// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: Tuse/Tnew codes, mul/div latencies, sequencer states.
// Constants only: no latency or backpressure behaviour of its own.
package pipe_ctrl_pkg;

  localparam logic [1:0] TNEW_NOW   = 2'd0;
  localparam logic [1:0] TUSE_NOW   = 2'd0;
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [4:0] EPC_NUM = 5'd14;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_state_e;

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// Multiply/divide busy sequencer: Busy rises the cycle after a start and holds for the op's cycle count.
// Starts are ignored while busy or when squashed by Req; Req never aborts a running op.
module md_seq
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  input  logic req,
  output logic busy
);

  md_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A start coinciding with Req belongs to a squashed instruction.
        if (start && !req) begin
          state_d = div ? DIV_BUSY : MUL_BUSY;
          cnt_d   = div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
        end
      end
      MUL_BUSY, DIV_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: combinational hazard detection to PC/IF-ID enables and ID/EX bubble, plus stall counter.
// Zero-cycle decision; Req overrides every stall cause so the exception flush can proceed.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  Tnew_E,
  input  logic [1:0]  Tnew_M,
  input  logic        MD_D,
  input  logic        Start_E,
  input  logic        Div_E,
  input  logic        Eret_D,
  input  logic        EPC_Wr_E,
  input  logic        EPC_Wr_M,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        ID_EX_clr,
  output logic        Busy,
  output logic [15:0] Stall_Cnt
);

  logic        stall_rs, stall_rt, stall_md, stall_eret, stall;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  md_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_seq (
    .clk   (clk),
    .reset (reset),
    .start (Start_E),
    .div   (Div_E),
    .req   (Req),
    .busy  (Busy)
  );

  // $0 is hardwired, so a match on it is never a real dependency.
  always_comb begin
    stall_rs   = (A1_D != 5'd0) &&
                 (((A1_D == A3_E) && (Tuse_rs_D < Tnew_E)) ||
                  ((A1_D == A3_M) && (Tuse_rs_D < Tnew_M)));
    stall_rt   = (A2_D != 5'd0) &&
                 (((A2_D == A3_E) && (Tuse_rt_D < Tnew_E)) ||
                  ((A2_D == A3_M) && (Tuse_rt_D < Tnew_M)));
    stall_md   = MD_D && (Start_E || Busy);
    stall_eret = Eret_D && (EPC_Wr_E || EPC_Wr_M);
    stall      = (stall_rs || stall_rt || stall_md || stall_eret) && !Req;
  end

  assign PC_en     = !stall;
  assign IF_ID_en  = !stall;
  assign ID_EX_clr = stall;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: per-cycle expected outputs from an independent model go through a scoreboard queue.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic [4:0]  a1_d = '0, a2_d = '0, a3_e = '0, a3_m = '0;
  logic [1:0]  tuse_rs = 2'd3, tuse_rt = 2'd3, tnew_e = 2'd0, tnew_m = 2'd0;
  logic        md_d = 1'b0, start_e = 1'b0, div_e = 1'b0;
  logic        eret_d = 1'b0, epc_wr_e = 1'b0, epc_wr_m = 1'b0;
  logic        pc_en, if_id_en, id_ex_clr, busy;
  logic [15:0] stall_cnt;

  typedef struct packed {
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_clr;
    logic        busy;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          m_busy_left = 0;
  logic [15:0] m_cnt = 16'd0;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (req),
    .A1_D      (a1_d),
    .A2_D      (a2_d),
    .Tuse_rs_D (tuse_rs),
    .Tuse_rt_D (tuse_rt),
    .A3_E      (a3_e),
    .A3_M      (a3_m),
    .Tnew_E    (tnew_e),
    .Tnew_M    (tnew_m),
    .MD_D      (md_d),
    .Start_E   (start_e),
    .Div_E     (div_e),
    .Eret_D    (eret_d),
    .EPC_Wr_E  (epc_wr_e),
    .EPC_Wr_M  (epc_wr_m),
    .PC_en     (pc_en),
    .IF_ID_en  (if_id_en),
    .ID_EX_clr (id_ex_clr),
    .Busy      (busy),
    .Stall_Cnt (stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_stall();
    logic hz_rs, hz_rt, hz_md, hz_eret;
    hz_rs   = (a1_d != 0) && ((a1_d == a3_e && tuse_rs < tnew_e) || (a1_d == a3_m && tuse_rs < tnew_m));
    hz_rt   = (a2_d != 0) && ((a2_d == a3_e && tuse_rt < tnew_e) || (a2_d == a3_m && tuse_rt < tnew_m));
    hz_md   = md_d && (start_e || m_busy_left > 0);
    hz_eret = eret_d && (epc_wr_e || epc_wr_m);
    return (hz_rs || hz_rt || hz_md || hz_eret) && !req;
  endfunction

  // One clock: predict, compare at negedge, then advance the model across the posedge.
  task automatic cyc(input string tag);
    exp_t e;
    logic s;
    @(negedge clk);
    s = model_stall();
    sb.push_back('{pc_en: !s, if_id_en: !s, id_ex_clr: s, busy: (m_busy_left > 0), cnt: m_cnt});
    e = sb.pop_front();
    chk({tag, ".pc_en"},     32'(pc_en),     32'(e.pc_en));
    chk({tag, ".if_id_en"},  32'(if_id_en),  32'(e.if_id_en));
    chk({tag, ".id_ex_clr"}, 32'(id_ex_clr), 32'(e.id_ex_clr));
    chk({tag, ".busy"},      32'(busy),      32'(e.busy));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(e.cnt));
    @(posedge clk);
    if (reset) begin
      m_busy_left = 0;
      m_cnt       = 16'd0;
    end else begin
      if (s) m_cnt = m_cnt + 16'd1;
      if (m_busy_left > 0) m_busy_left--;
      else if (start_e && !req) m_busy_left = div_e ? 10 : 5;
    end
    #1;
  endtask

  task automatic idle_inputs();
    req = 0; a1_d = 0; a2_d = 0; a3_e = 0; a3_m = 0;
    tuse_rs = 3; tuse_rt = 3; tnew_e = 0; tnew_m = 0;
    md_d = 0; start_e = 0; div_e = 0; eret_d = 0; epc_wr_e = 0; epc_wr_m = 0;
  endtask

  initial begin
    // Reset, including a start request that reset must override.
    start_e = 1;
    cyc("reset_start");
    start_e = 0;
    a1_d = 5; a3_e = 5; tnew_e = 2; tuse_rs = 0;
    cyc("reset_hazard");
    idle_inputs();
    reset = 0;
    cyc("idle");

    // rs hazard from E, then $0 never stalls.
    a1_d = 5; a3_e = 5; tnew_e = 2; tuse_rs = 0;
    cyc("rs_e_hazard");
    a1_d = 0; a3_e = 0;
    cyc("rs_zero");
    idle_inputs();

    // rt hazard from M, and the Tuse == Tnew boundary that must not stall.
    a2_d = 7; a3_m = 7; tnew_m = 1; tuse_rt = 0;
    cyc("rt_m_hazard");
    tuse_rt = 1;
    cyc("rt_m_equal");
    tuse_rt = 3; tnew_m = 2;
    cyc("rt_never");
    idle_inputs();

    // Multiply with MD_D held high throughout.
    md_d = 1; start_e = 1; div_e = 0;
    cyc("mul_start");
    start_e = 0;
    for (int i = 0; i < 6; i++) cyc("mul_busy");
    md_d = 0;
    cyc("mul_done");

    // Divide with Req pulsed on the third busy cycle.
    start_e = 1; div_e = 1;
    cyc("div_start");
    start_e = 0; md_d = 1;
    for (int i = 1; i <= 11; i++) begin
      req = (i == 3);
      cyc("div_busy");
    end
    idle_inputs();

    // Start squashed by Req, then eret against pending EPC writes.
    start_e = 1; req = 1; md_d = 1;
    cyc("start_req");
    idle_inputs();
    cyc("start_req_after");
    eret_d = 1; epc_wr_m = 1;
    cyc("eret_m");
    epc_wr_m = 0; epc_wr_e = 1;
    cyc("eret_e");
    req = 1; a1_d = 9; a3_e = 9; tnew_e = 2; tuse_rs = 0;
    cyc("req_override");
    idle_inputs();

    // Counter wrap: start from a fresh reset and stall for 65536 cycles.
    reset = 1;
    cyc("wrap_reset");
    reset = 0;
    a1_d = 4; a3_e = 4; tnew_e = 2; tuse_rs = 0;
    for (int i = 0; i < 65536; i++) cyc("wrap_stall");
    idle_inputs();
    chk("wrap_zero", 32'(stall_cnt), 32'd0);
    cyc("wrap_after");

    // Reset mid-divide.
    a1_d = 4; a3_e = 4; tnew_e = 2; tuse_rs = 0;
    cyc("pre_div_stall");
    idle_inputs();
    start_e = 1; div_e = 1;
    cyc("div2_start");
    start_e = 0;
    cyc("div2_busy");
    cyc("div2_busy");
    reset = 1;
    cyc("div2_reset");
    reset = 0;
    cyc("div2_after_reset");
    cyc("div2_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles following a mult/multu start.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles following a div/divu start.
REQ-003 clk  in  1  single system clock; all state updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Req  in  1  CP0 exception/interrupt request; pipeline registers self-flush on it.
REQ-006 A1_D, A2_D  in  5 each  rs/rt register numbers of the instruction in D.
REQ-007 Tuse_rs_D, Tuse_rt_D  in  2 each  cycles until D instruction needs rs/rt (3 = never).
REQ-008 A3_E, A3_M  in  5 each  destination register of the instruction in E/M.
REQ-009 Tnew_E, Tnew_M  in  2 each  cycles until E/M result is forwardable (0 = available now).
REQ-010 MD_D  in  1  D instruction accesses HI/LO or the multiply/divide unit.
REQ-011 Start_E  in  1  mult/multu/div/divu present in E.
REQ-012 Div_E  in  1  qualifies Start_E: 1 = divide, 0 = multiply.
REQ-013 Eret_D  in  1  eret in D.
REQ-014 EPC_Wr_E, EPC_Wr_M  in  1 each  mtc0 to EPC (CP0 reg 14) in E/M.
REQ-015 PC_en  out  1  PC write enable.
REQ-016 IF_ID_en  out  1  IF/ID register write enable.
REQ-017 ID_EX_clr  out  1  inserts a bubble into ID/EX (preserves PC and BD).
REQ-018 Busy  out  1  multiply/divide unit busy.
REQ-019 Stall_Cnt  out  16  count of stall cycles since reset.

Function
REQ-020 Stall_rs SHALL be (A1_D != 0) and ((A1_D == A3_E and Tuse_rs_D < Tnew_E) or (A1_D == A3_M and Tuse_rs_D < Tnew_M)); Stall_rt is identical with A2_D and Tuse_rt_D.
REQ-021 Stall_md SHALL be MD_D and (Start_E or Busy).
REQ-022 Stall_eret SHALL be Eret_D and (EPC_Wr_E or EPC_Wr_M).
REQ-023 Stall SHALL be (Stall_rs or Stall_rt or Stall_md or Stall_eret) and not Req.
REQ-024 Outputs SHALL be combinational: PC_en = IF_ID_en = not Stall; ID_EX_clr = Stall.
REQ-025 While Req = 1, the block SHALL drive PC_en = 1, IF_ID_en = 1, and ID_EX_clr = 0, with no stall asserted.
REQ-026 Multiply/divide sequencer SHALL have states IDLE, MUL_BUSY and DIV_BUSY, plus a 4-bit down-counter.
REQ-027 In IDLE, if Start_E and not Req, the sequencer SHALL go next cycle to MUL_BUSY (counter = MULT_CYCLES-1) or DIV_BUSY (counter = DIV_CYCLES-1), selected by Div_E.
REQ-028 In a BUSY state, the counter SHALL decrement each cycle; when the counter is 0, the next state SHALL be IDLE.
REQ-029 Busy SHALL be 1 exactly when the state is not IDLE, giving exactly MULT_CYCLES or DIV_CYCLES busy cycles after the start cycle.
REQ-030 Start_E SHALL be ignored while not in IDLE; Stall_md guarantees this cannot occur legally.
REQ-031 Start_E in the same cycle as Req SHALL NOT start an operation, because that instruction is squashed.
REQ-032 Req arriving during a BUSY state SHALL NOT abort the operation; the count runs to completion.
REQ-033 Stall_Cnt SHALL increment by 1 on each clock edge at which Stall = 1, and SHALL wrap from 16'hFFFF to 0.
REQ-034 Simultaneous stall causes SHALL count once per cycle.

Reset
REQ-035 On reset, the block SHALL set state = IDLE, counter = 0, Busy = 0 and Stall_Cnt = 0; reset overrides Start_E in the same cycle.
REQ-036 Combinational outputs during reset SHALL follow REQ-024 from the current inputs.
REQ-037 Reset asserted mid-operation SHALL return the sequencer to IDLE at the next edge.

Structure
REQ-038 A shared package SHALL hold the Tuse/Tnew encodings (including TUSE_NEVER = 3), the MULT_CYCLES/DIV_CYCLES defaults, the state encoding, and the constant EPC_NUM = 14.
REQ-039 One sub-module, md_seq, SHALL contain the state machine and counter and output Busy; hazard comparison and Stall_Cnt SHALL stay in pipe_ctrl.

Verification
REQ-040 Scenario: A3_E = 5, Tnew_E = 2, A1_D = 5, Tuse_rs_D = 0 -> Stall = 1, PC_en = 0, ID_EX_clr = 1 for that cycle, Stall_Cnt +1.
REQ-041 Scenario: A1_D = 0 matching A3_E = 0 with Tnew_E = 2 -> no stall.
REQ-042 Scenario: Start_E = 1, Div_E = 0 at cycle t -> Busy = 1 for cycles t+1..t+5, 0 at t+6; MD_D held high -> stall for cycles t..t+5.
REQ-043 Scenario: Start_E = 1, Div_E = 1 -> 10 busy cycles; Req pulsed at busy cycle 3 -> Busy remains 1 through cycle 10; stall is 0 during the Req cycle.
REQ-044 Scenario: Start_E = 1 with Req = 1 in the same cycle -> Busy stays 0; Eret_D = 1 with EPC_Wr_M = 1 -> Stall = 1.
REQ-045 Scenario: 65536 consecutive stall cycles -> Stall_Cnt returns to 0; reset asserted during DIV_BUSY -> Busy = 0 and Stall_Cnt = 0 at the next edge.
